ebi_bus_resizer: RTL and testbench

Memory-side adapter for the V810 external bus interface (EBI). It sits between the EBI controller pins (DAn, BEn, READYn, SZRQn, D) and a 32-bit-wide synchronous RAM model. It emulates a memory device of selectable data width (32 or 16 bit) with a selectable number of wait states, so the controller's bus-sizing and wait logic can be exercised without changing the RAM. It is purely a bench/peripheral block and holds no storage of its own beyond a wait counter.

---
 rtl/ebi_bus_resizer.sv | 77 +++++++
 tb/tb_ebi_bus_resizer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebi_bus_resizer.sv
// ebi_bus_resizer: emulates a 32/16-bit EBI memory with wait states.
// Define BUS_RESIZER_CHECK_EN to compile in simulation-only bus checks.
module ebi_bus_resizer (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic [31:0] WS,
  input  logic [31:0] DW,
  input  logic        CTLR_DAn,
  input  logic [3:0]  CTLR_BEn,
  output logic        CTLR_READYn,
  output logic        CTLR_SZRQn,
  output logic [31:0] CTLR_DI,
  input  logic [31:0] CTLR_DO,
  output logic [31:0] MEM_DI,
  input  logic [31:0] MEM_DO
);

  logic [3:0]  r_cnt;
  logic [3:0]  w_ws_eff;
  logic        w_ready;
  logic        w_is16;
  logic        w_hi;
  logic [15:0] w_half;
  logic        w_unused;

  assign w_ws_eff = (WS > 32'd15) ? 4'hF : WS[3:0];
  assign w_is16   = (DW == 32'd16);
  assign w_hi     = &CTLR_BEn[1:0];
  assign w_ready  = ~CTLR_DAn & (r_cnt == w_ws_eff);
  assign w_unused = ^CTLR_BEn[3:2];

  // Bus handshake outputs; released (high) whenever DAn is high.
  always_comb begin
    CTLR_READYn = ~w_ready;
    CTLR_SZRQn  = ~(~CTLR_DAn & w_is16);
  end

  // Data steering; a 16-bit device sits on lanes [15:0].
  always_comb begin
    w_half = w_hi ? MEM_DO[31:16] : MEM_DO[15:0];
    if (w_is16) begin
      CTLR_DI = {16'h0000, w_half};
      MEM_DI  = {CTLR_DO[15:0], CTLR_DO[15:0]};
    end else begin
      CTLR_DI = MEM_DO;
      MEM_DI  = CTLR_DO;
    end
  end

  // Wait counter; restarts on idle bus and after each ready beat.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      r_cnt <= 4'd0;
    end else if (CE) begin
      if (CTLR_DAn || w_ready)
        r_cnt <= 4'd0;
      else
        r_cnt <= r_cnt + 4'd1;
    end
  end

`ifdef BUS_RESIZER_CHECK_EN
  // Flag illegal controller behaviour seen by this device.
  always_ff @(posedge CLK) begin
    if (RESn && !CTLR_DAn) begin
      if (CTLR_BEn == 4'hF)
        $error("ebi_bus_resizer: data phase with no lanes");
      if (w_is16 && !(&CTLR_BEn[1:0]) && !(&CTLR_BEn[3:2]))
        $error("ebi_bus_resizer: 16-bit beat spans both halves");
      if (w_ready && $isunknown(CTLR_DI))
        $error("ebi_bus_resizer: unknown read data at ready");
    end
  end
`endif

endmodule

// File: tb/tb_ebi_bus_resizer.sv
// tb_ebi_bus_resizer: directed checks of ready timing and data steering.
// Inputs change on falling edges; outputs are sampled 1 ns later.
module tb_ebi_bus_resizer;

  logic        CLK = 1'b0;
  logic        RESn;
  logic        CE;
  logic [31:0] WS;
  logic [31:0] DW;
  logic        CTLR_DAn;
  logic [3:0]  CTLR_BEn;
  logic        CTLR_READYn;
  logic        CTLR_SZRQn;
  logic [31:0] CTLR_DI;
  logic [31:0] CTLR_DO;
  logic [31:0] MEM_DI;
  logic [31:0] MEM_DO;

  int total = 0;
  int bad = 0;

  ebi_bus_resizer dut (
    .CLK(CLK),
    .RESn(RESn),
    .CE(CE),
    .WS(WS),
    .DW(DW),
    .CTLR_DAn(CTLR_DAn),
    .CTLR_BEn(CTLR_BEn),
    .CTLR_READYn(CTLR_READYn),
    .CTLR_SZRQn(CTLR_SZRQn),
    .CTLR_DI(CTLR_DI),
    .CTLR_DO(CTLR_DO),
    .MEM_DI(MEM_DI),
    .MEM_DO(MEM_DO)
  );

  always #5 CLK = ~CLK;

  task automatic test_reset;
    RESn = 1'b0; CE = 1'b1; WS = 0; DW = 32;
    CTLR_DAn = 1'b1; CTLR_BEn = 4'hF;
    CTLR_DO = 0; MEM_DO = 0;
    @(negedge CLK); #1;
    total++;
    if (CTLR_READYn !== 1'b1) begin
      bad++; $display("FAIL rst_ready got=%b exp=1", CTLR_READYn);
    end
    total++;
    if (CTLR_SZRQn !== 1'b1) begin
      bad++; $display("FAIL rst_szrq got=%b exp=1", CTLR_SZRQn);
    end
    DW = 16; #1;
    total++;
    if (CTLR_SZRQn !== 1'b1) begin
      bad++; $display("FAIL rst_szrq16_idle got=%b exp=1", CTLR_SZRQn);
    end
    CTLR_DAn = 1'b0; CTLR_BEn = 4'h0; #1;
    total++;
    if (CTLR_READYn !== 1'b0) begin
      bad++; $display("FAIL rst_cnt0_ready got=%b exp=0", CTLR_READYn);
    end
    total++;
    if (CTLR_SZRQn !== 1'b0) begin
      bad++; $display("FAIL rst_szrq16_busy got=%b exp=0", CTLR_SZRQn);
    end
    CTLR_DAn = 1'b1; CTLR_BEn = 4'hF; DW = 32;
    @(negedge CLK);
    RESn = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_zero_wait;
    DW = 32; WS = 0; MEM_DO = 32'h12345678;
    @(negedge CLK);
    CTLR_DAn = 1'b0; CTLR_BEn = 4'h0; #1;
    total++;
    if (CTLR_READYn !== 1'b0) begin
      bad++; $display("FAIL zw_ready got=%b exp=0", CTLR_READYn);
    end
    total++;
    if (CTLR_SZRQn !== 1'b1) begin
      bad++; $display("FAIL zw_szrq got=%b exp=1", CTLR_SZRQn);
    end
    total++;
    if (CTLR_DI !== 32'h12345678) begin
      bad++; $display("FAIL zw_di got=%h exp=12345678", CTLR_DI);
    end
    @(negedge CLK);
    CTLR_DAn = 1'b1; CTLR_BEn = 4'hF; #1;
    total++;
    if (CTLR_READYn !== 1'b1) begin
      bad++; $display("FAIL zw_idle got=%b exp=1", CTLR_READYn);
    end
  endtask

  task automatic test_two_waits;
    logic exp_r [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    WS = 2; DW = 32;
    @(negedge CLK);
    CTLR_DAn = 1'b0; CTLR_BEn = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      total++;
      if (CTLR_READYn !== exp_r[i]) begin
        bad++;
        $display("FAIL ws2_c%0d got=%b exp=%b", i, CTLR_READYn, exp_r[i]);
      end
    end
    @(negedge CLK);
    CTLR_DAn = 1'b1; CTLR_BEn = 4'hF;
  endtask

  task automatic test_16bit_read;
    DW = 16; WS = 0; MEM_DO = 32'hAAAA5555;
    @(negedge CLK);
    CTLR_DAn = 1'b0; CTLR_BEn = 4'b0011; #1;
    total++;
    if (CTLR_DI !== 32'h0000AAAA) begin
      bad++; $display("FAIL rd16_hi got=%h exp=0000aaaa", CTLR_DI);
    end
    total++;
    if (CTLR_SZRQn !== 1'b0) begin
      bad++; $display("FAIL rd16_szrq got=%b exp=0", CTLR_SZRQn);
    end
    total++;
    if (CTLR_READYn !== 1'b0) begin
      bad++; $display("FAIL rd16_ready got=%b exp=0", CTLR_READYn);
    end
    @(negedge CLK);
    CTLR_BEn = 4'b1100; #1;
    total++;
    if (CTLR_DI !== 32'h00005555) begin
      bad++; $display("FAIL rd16_lo got=%h exp=00005555", CTLR_DI);
    end
    @(negedge CLK);
    CTLR_DAn = 1'b1; CTLR_BEn = 4'b0111; #1;
    total++;
    if (CTLR_DI !== 32'h0000AAAA) begin
      bad++; $display("FAIL rd16_idle got=%h exp=0000aaaa", CTLR_DI);
    end
    CTLR_BEn = 4'hF;
  endtask

  task automatic test_write_paths;
    DW = 16; WS = 0; CTLR_DO = 32'h0000BEEF;
    @(negedge CLK);
    CTLR_DAn = 1'b0; CTLR_BEn = 4'b1100; #1;
    total++;
    if (MEM_DI !== 32'hBEEFBEEF) begin
      bad++; $display("FAIL wr16 got=%h exp=beefbeef", MEM_DI);
    end
    @(negedge CLK);
    CTLR_DAn = 1'b1; CTLR_BEn = 4'hF;
    DW = 32; CTLR_DO = 32'hDEADBEEF;
    MEM_DO = 32'hCAFEF00D; #1;
    total++;
    if (MEM_DI !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wr32 got=%h exp=deadbeef", MEM_DI);
    end
    DW = 8; CTLR_DO = 32'h1234ABCD; #1;
    total++;
    if (MEM_DI !== 32'h1234ABCD) begin
      bad++; $display("FAIL wr_dw8 got=%h exp=1234abcd", MEM_DI);
    end
    total++;
    if (CTLR_DI !== 32'hCAFEF00D) begin
      bad++; $display("FAIL rd_dw8 got=%h exp=cafef00d", CTLR_DI);
    end
    DW = 32;
  endtask

  task automatic test_back_to_back;
    logic exp_r [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    WS = 1;
    @(negedge CLK);
    CTLR_DAn = 1'b0; CTLR_BEn = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      total++;
      if (CTLR_READYn !== exp_r[i]) begin
        bad++;
        $display("FAIL b2b_c%0d got=%b exp=%b", i, CTLR_READYn, exp_r[i]);
      end
    end
    @(negedge CLK);
    CTLR_DAn = 1'b1; CTLR_BEn = 4'hF;
  endtask

  task automatic test_ws_clamp;
    logic exp_b;
    WS = 20;
    @(negedge CLK);
    CTLR_DAn = 1'b0; CTLR_BEn = 4'h0;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      exp_b = (i == 15) ? 1'b0 : 1'b1;
      total++;
      if (CTLR_READYn !== exp_b) begin
        bad++;
        $display("FAIL clamp_c%0d got=%b exp=%b", i, CTLR_READYn, exp_b);
      end
    end
    @(negedge CLK);
    CTLR_DAn = 1'b1; CTLR_BEn = 4'hF;
  endtask

  task automatic test_ce_freeze;
    WS = 2;
    @(negedge CLK);
    CTLR_DAn = 1'b0; CTLR_BEn = 4'h0; CE = 1'b1;
    @(negedge CLK);
    CE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      total++;
      if (CTLR_READYn !== 1'b1) begin
        bad++; $display("FAIL ce_hold_c%0d got=%b exp=1", i, CTLR_READYn);
      end
    end
    CE = 1'b1;
    @(negedge CLK); #1;
    total++;
    if (CTLR_READYn !== 1'b0) begin
      bad++; $display("FAIL ce_resume got=%b exp=0", CTLR_READYn);
    end
    @(negedge CLK);
    CTLR_DAn = 1'b1; CTLR_BEn = 4'hF;
  endtask

  task automatic test_reset_mid;
    logic exp_r [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    WS = 3;
    @(negedge CLK);
    CTLR_DAn = 1'b0; CTLR_BEn = 4'h0;
    @(negedge CLK);
    @(negedge CLK);
    RESn = 1'b0; #1;
    total++;
    if (CTLR_READYn !== 1'b1) begin
      bad++; $display("FAIL rmid_in_rst got=%b exp=1", CTLR_READYn);
    end
    @(negedge CLK);
    RESn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      total++;
      if (CTLR_READYn !== exp_r[i]) begin
        bad++;
        $display("FAIL rmid_c%0d got=%b exp=%b", i, CTLR_READYn, exp_r[i]);
      end
    end
    @(negedge CLK);
    CTLR_DAn = 1'b1; CTLR_BEn = 4'hF;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_two_waits();
    test_16bit_read();
    test_write_paths();
    test_back_to_back();
    test_ws_clamp();
    test_ce_freeze();
    test_reset_mid();
    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
